// File: rtl/nibble_max_frame_if.sv
// Frame-max handshake bundle: upstream sample stream, frame result and frame counter.
// The master modport is the environment side and the slave modport is the block side.
interface nibble_max_frame_if #(
    parameter int IDX_W = 3
);
    logic [3:0]       fm_in_nibble;
    logic             fm_in_valid;
    logic             fm_in_ready;
    logic             fm_clear;
    logic             fm_out_valid;
    logic             fm_out_ready;
    logic [3:0]       fm_out_max;
    logic [IDX_W-1:0] fm_out_idx;
    logic [7:0]       fm_frames;

    modport master (
        output fm_in_nibble, fm_in_valid, fm_clear, fm_out_ready,
        input  fm_in_ready, fm_out_valid, fm_out_max, fm_out_idx, fm_frames
    );

    modport slave (
        input  fm_in_nibble, fm_in_valid, fm_clear, fm_out_ready,
        output fm_in_ready, fm_out_valid, fm_out_max, fm_out_idx, fm_frames
    );
endinterface

// File: rtl/nibble_max_frame.sv
// Tracks the largest nibble (first occurrence) over fixed-length frames and holds
// the result until the consumer takes it; a two-state ACCUM/HOLD machine.
module nibble_max_frame #(
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = 3
) (
    input  logic                clk,
    input  logic                reset,
    nibble_max_frame_if.slave   fm
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic [3:0]       run_max_q;
    logic [IDX_W-1:0] run_idx_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [3:0]       out_max_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [7:0]       frames_q;

    logic [3:0]       run_max_d;
    logic [IDX_W-1:0] run_idx_d;

    // Running max including the sample currently on the bus; first sample always loads.
    always_comb begin
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        if ((cnt_q == {IDX_W{1'b0}}) || (fm.fm_in_nibble > run_max_q)) begin
            run_max_d = fm.fm_in_nibble;
            run_idx_d = cnt_q;
        end else begin
            run_max_d = run_max_q;
            run_idx_d = run_idx_q;
        end
    end

    // Frame state machine with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ACCUM;
            cnt_q       <= {IDX_W{1'b0}};
            run_max_q   <= 4'd0;
            run_idx_q   <= {IDX_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_max_q   <= 4'd0;
            out_idx_q   <= {IDX_W{1'b0}};
            frames_q    <= 8'd0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (fm.fm_clear) begin
                        cnt_q <= {IDX_W{1'b0}};
                    end else if (fm.fm_in_valid) begin
                        run_max_q <= run_max_d;
                        run_idx_q <= run_idx_d;
                        cnt_q     <= cnt_q + IDX_W'(1);
                        if (cnt_q == LAST_IDX) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_max_q   <= run_max_d;
                            out_idx_q   <= run_idx_d;
                            frames_q    <= frames_q + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    // Clear and consumer-take have the same effect here, so one branch covers both.
                    if (fm.fm_clear || fm.fm_out_ready) begin
                        state_q     <= ACCUM;
                        cnt_q       <= {IDX_W{1'b0}};
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACCUM;
                    cnt_q       <= {IDX_W{1'b0}};
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fm.fm_in_ready  = in_ready_q;
    assign fm.fm_out_valid = out_valid_q;
    assign fm.fm_out_max   = out_max_q;
    assign fm.fm_out_idx   = out_idx_q;
    assign fm.fm_frames    = frames_q;
endmodule

// File: doc/nibble_max_frame.md
NIBBLE_MAX_FRAME -- requirements
Module: nibble_max_frame

Interface
REQ-001 Parameter: FRAME_LEN, default 8, number of nibbles per frame; legal values 2..16, power of two.
REQ-002 Parameter: IDX_W, default 3, width of the index output; equals log2(FRAME_LEN).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; asserted at 0.
REQ-005 Port: fm_in_nibble  input  4  greater-nibble result from the upstream nibble comparator stage.
REQ-006 Port: fm_in_valid  input  1  fm_in_nibble carries a sample this cycle.
REQ-007 Port: fm_in_ready  output  1  block accepts a sample this cycle.
REQ-008 Port: fm_clear  input  1  synchronous abort of the current frame.
REQ-009 Port: fm_out_valid  output  1  frame result available.
REQ-010 Port: fm_out_ready  input  1  consumer takes the frame result.
REQ-011 Port: fm_out_max  output  4  largest nibble of the completed frame.
REQ-012 Port: fm_out_idx  output  IDX_W  position (0-based) of the first occurrence of fm_out_max in the frame.
REQ-013 Port: fm_frames  output  8  count of completed frames, modulo 256.

Function
REQ-014 The block SHALL have exactly two states: ACCUM (collecting samples) and HOLD (presenting a result).
REQ-015 A sample is accepted when fm_in_valid=1 and fm_in_ready=1 at a rising edge.
REQ-016 fm_in_ready SHALL be 1 in ACCUM and 0 in HOLD, with no dependence on fm_in_valid.
REQ-017 fm_out_valid SHALL be 1 in HOLD and 0 in ACCUM, registered.
REQ-018 A sample counter (IDX_W bits) SHALL increment on each accepted sample and wrap to 0 after FRAME_LEN-1.
REQ-019 The running max SHALL load unconditionally from the first sample (counter=0) of each frame.
REQ-020 For later samples, the running max and index SHALL update only when the sample is strictly greater than the running max; ties keep the earlier index.
REQ-021 On acceptance of the sample with counter=FRAME_LEN-1:
  - the state SHALL move to HOLD;
  - fm_out_max/fm_out_idx SHALL load the final max/index, including that last sample;
  - fm_frames SHALL increment.
  All three take effect at that same edge, so fm_out_valid is high in the next cycle (latency 1 cycle from the last accepted sample).
REQ-022 fm_out_max, fm_out_idx and fm_frames SHALL change only at the REQ-021 edge and remain stable through HOLD and afterwards until the next frame completes.
REQ-023 In HOLD, fm_out_ready=1 at an edge SHALL return the state to ACCUM with the counter at 0; fm_out_valid drops in the following cycle.
REQ-024 In HOLD with fm_out_ready=0, the state SHALL remain HOLD indefinitely; upstream samples are back-pressured, not dropped.
REQ-025 fm_clear=1 in ACCUM SHALL zero the counter and discard the partial frame; any sample presented in that same cycle is discarded (not counted, not compared).
REQ-026 fm_clear=1 in HOLD SHALL return the state to ACCUM and drop fm_out_valid; fm_out_max, fm_out_idx and fm_frames keep their values.
REQ-027 fm_clear takes priority over a simultaneous fm_out_ready or sample acceptance; the outcome is identical to clear alone.
REQ-028 fm_frames SHALL wrap from 255 to 0 without any flag.

Reset
REQ-029 While reset=0, the block SHALL asynchronously force:
  - state ACCUM and counter 0;
  - running max 0 and running index 0;
  - fm_out_valid=0, fm_out_max=0, fm_out_idx=0, fm_frames=0.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard all partial or held results.
REQ-031 fm_in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Frame 3,9,2,9,1,0,7,4 with fm_out_ready=1 -> fm_out_valid pulses one cycle after the 8th accept; fm_out_max=9, fm_out_idx=1, fm_frames=1.
REQ-033 Hold fm_out_ready=0 for 5 cycles after completion with fm_in_valid=1 -> fm_in_ready=0 and outputs stable for 5 cycles; fm_out_ready=1 -> fm_in_ready=1 next cycle; next frame starts at index 0.
REQ-034 Frame of all zeros -> fm_out_max=0, fm_out_idx=0; frame F,...,F -> fm_out_max=F, fm_out_idx=0.
REQ-035 fm_clear after 5 samples including a sample of value F, then a new frame of eight 2s -> fm_out_max=2, fm_out_idx=0; fm_frames increments by 1 only.
REQ-036 Reset=0 asserted in HOLD (fm_out_max=9) -> fm_out_valid=0, fm_out_max=0, fm_frames=0 immediately, before any clock edge.
REQ-037 Run 256 frames back-to-back -> fm_frames reaches 255, then returns to 0 on completion of frame 256.
